// File: rtl/drive_cmd_arbiter.sv
// Registered drive-command arbiter: one-hot source select, zero-command guard on
// every source switch, and a conflicting-pair filter. Optional macro: DRIVE_CMD_SYNC_EN.
module drive_cmd_arbiter #(
  parameter int NUM_SRC      = 3,
  parameter int GUARD_CYCLES = 16,
  parameter int CNT_W        = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_SRC-1:0]   mode,
  input  logic [4*NUM_SRC-1:0] src_cmd,
  output logic [3:0]           cmd_out,
  output logic [NUM_SRC-1:0]   active_src,
  output logic                 guard_busy,
  output logic                 conflict
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GUARD  = 2'd1,
    ACTIVE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] GUARD_LOAD = CNT_W'(GUARD_CYCLES - 1);

  state_t               state;
  logic [NUM_SRC-1:0]   sel;
  logic [CNT_W-1:0]     cnt;
  logic [NUM_SRC-1:0]   mode_use;
  logic [4*NUM_SRC-1:0] src_use;

`ifdef DRIVE_CMD_SYNC_EN
  logic [NUM_SRC-1:0]   mode_q1, mode_q2;
  logic [4*NUM_SRC-1:0] src_q1, src_q2;

  // Two-flop synchronizers for inputs coming from other clock domains.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q1 <= '0;
      mode_q2 <= '0;
      src_q1  <= '0;
      src_q2  <= '0;
    end else begin
      mode_q1 <= mode;
      mode_q2 <= mode_q1;
      src_q1  <= src_cmd;
      src_q2  <= src_q1;
    end
  end

  assign mode_use = mode_q2;
  assign src_use  = src_q2;
`else
  assign mode_use = mode;
  assign src_use  = src_cmd;
`endif

  logic       mode_valid;
  logic [3:0] src_sel;
  logic [3:0] src_filt;
  logic       src_conflict;

  assign mode_valid = (mode_use != '0) &&
                      ((mode_use & (mode_use - NUM_SRC'(1))) == '0);

  // NOTE: every variable assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    src_sel = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (sel[i]) src_sel = src_sel | src_use[4*i +: 4];
    end
  end

  // Bit order {turn_left, turn_right, move_backward, move_forward}.
  always_comb begin
    src_filt     = src_sel;
    src_conflict = 1'b0;
    if (src_sel[3] && src_sel[2]) begin
      src_filt[3:2] = 2'b00;
      src_conflict  = 1'b1;
    end
    if (src_sel[1] && src_sel[0]) begin
      src_filt[1:0] = 2'b00;
      src_conflict  = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      sel        <= '0;
      cnt        <= '0;
      cmd_out    <= '0;
      active_src <= '0;
      guard_busy <= 1'b0;
      conflict   <= 1'b0;
    end else begin
      // Defaults: zero command, no conflict; ACTIVE overrides below.
      cmd_out    <= '0;
      active_src <= '0;
      conflict   <= 1'b0;
      case (state)
        IDLE: begin
          guard_busy <= 1'b0;
          if (mode_valid) begin
            sel        <= mode_use;
            cnt        <= GUARD_LOAD;
            state      <= GUARD;
            guard_busy <= 1'b1;
          end
        end

        GUARD: begin
          if (!mode_valid) begin
            state      <= IDLE;
            guard_busy <= 1'b0;
          end else if (mode_use != sel) begin
            sel        <= mode_use;
            cnt        <= GUARD_LOAD;
            guard_busy <= 1'b1;
          end else if (cnt == '0) begin
            state      <= ACTIVE;
            guard_busy <= 1'b0;
            cmd_out    <= src_filt;
            active_src <= sel;
            conflict   <= src_conflict;
          end else begin
            cnt        <= cnt - CNT_W'(1);
            guard_busy <= 1'b1;
          end
        end

        ACTIVE: begin
          if (!mode_valid) begin
            state      <= IDLE;
            guard_busy <= 1'b0;
          end else if (mode_use != sel) begin
            sel        <= mode_use;
            cnt        <= GUARD_LOAD;
            state      <= GUARD;
            guard_busy <= 1'b1;
          end else begin
            guard_busy <= 1'b0;
            cmd_out    <= src_filt;
            active_src <= sel;
            conflict   <= src_conflict;
          end
        end

        default: begin
          state      <= IDLE;
          guard_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule
